rgmii_rx_word_packer: RTL and testbench

//  Packs the decoded RGMII receive byte stream (data/val/sof/eof/err) into

---
 rtl/rgmii_rx_word_packer_if.sv | 22 ++
 rtl/rgmii_rx_word_packer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_rgmii_rx_word_packer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_rx_word_packer_if.sv
// AXI-Stream word bus carrying packed RGMII receive frames.
// The master drives data/keep/last/user/valid; the slave returns ready.
interface rgmii_rx_word_packer_if #(
    parameter int unsigned BYTES = 4
);
    logic [8*BYTES-1:0] m_tdata;
    logic [BYTES-1:0]   m_tkeep;
    logic               m_tlast;
    logic               m_tuser;
    logic               m_tvalid;
    logic               m_tready;

    modport master (
        output m_tdata, m_tkeep, m_tlast, m_tuser, m_tvalid,
        input  m_tready
    );

    modport slave (
        input  m_tdata, m_tkeep, m_tlast, m_tuser, m_tvalid,
        output m_tready
    );
endinterface

// File: rtl/rgmii_rx_word_packer.sv
// Packs the decoded RGMII receive byte stream into BYTES-wide AXI-Stream words through a
// first-word-fall-through FIFO, enforcing frame-length limits and overflow-safe framing.
module rgmii_rx_word_packer #(
    parameter int unsigned BYTES      = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MIN_FRAME  = 64,
    parameter int unsigned MAX_FRAME  = 1522
) (
    input  logic                          clk125,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_val,
    input  logic                          in_sof,
    input  logic                          in_eof,
    input  logic                          in_err,
    rgmii_rx_word_packer_if.master        m_axis,
    output logic [15:0]                   frame_cnt,
    output logic [15:0]                   err_cnt,
    output logic [15:0]                   ovf_cnt
);
    localparam int unsigned PW = $clog2(BYTES) + 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned DW = 8 * BYTES;
    localparam int unsigned WW = DW + BYTES + 2;

    typedef enum logic [1:0] {StIdle, StPack, StDrop} state_e;

    function automatic logic [BYTES-1:0] keep_of(input logic [PW-1:0] n);
        logic [BYTES-1:0] k;
        for (int i = 0; i < BYTES; i++) k[i] = (PW'(i) < n);
        return k;
    endfunction

    // Input byte register
    logic [7:0] data_q, data_d;
    logic       val_q, val_d, sof_q, sof_d, eof_q, eof_d, err_q, err_d;

    // Frame assembly state
    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [15:0]     len_q, len_d;
    logic            ferr_q, ferr_d;
    logic            pushed_q, pushed_d;
    logic [DW-1:0]   word_q, word_d;

    // Registered push toward the FIFO: {user, last, keep, data}
    logic            push_q, push_d;
    logic [WW-1:0]   pw_q, pw_d;

    // FIFO
    logic [WW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   rd_word;
    logic            pop;

    logic [15:0]     frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d;

    // Combinational working values
    logic [CW-1:0]   occ;
    logic            room_mid, room_last;
    logic            accept, closing, frame_bad;
    logic            frame_inc, err_inc, ovf_inc;
    logic [PW-1:0]   cur_ptr, ptr_n;
    logic [15:0]     cur_len, len_n;
    logic            cur_err, cur_pushed, err_n;
    logic [DW-1:0]   word_n;

    always_comb begin
        data_d = in_data;
        val_d  = in_val;
        sof_d  = in_sof;
        eof_d  = in_eof;
        err_d  = in_err;
    end

    // Occupancy includes the push still in flight; non-last words keep a slot in reserve
    // so a frame that already emitted words can always be terminated.
    always_comb begin
        occ       = cnt_q + CW'(push_q);
        room_mid  = occ < CW'(FIFO_DEPTH - 2);
        room_last = occ < CW'(FIFO_DEPTH);
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        ferr_d     = ferr_q;
        pushed_d   = pushed_q;
        word_d     = word_q;
        push_d     = 1'b0;
        pw_d       = '0;
        frame_inc  = 1'b0;
        err_inc    = 1'b0;
        ovf_inc    = 1'b0;
        accept     = 1'b0;
        closing    = 1'b0;
        frame_bad  = 1'b0;
        cur_ptr    = ptr_q;
        cur_len    = len_q;
        cur_err    = ferr_q;
        cur_pushed = pushed_q;
        word_n     = word_q;
        ptr_n      = '0;
        len_n      = '0;
        err_n      = 1'b0;

        if (val_q) begin
            if (sof_q) begin
                accept     = 1'b1;
                cur_ptr    = '0;
                cur_len    = '0;
                cur_err    = 1'b0;
                cur_pushed = 1'b0;
                if (state_q == StPack) begin
                    closing = 1'b1;
                    if (pushed_q || room_last) begin
                        push_d  = 1'b1;
                        pw_d    = {1'b1, 1'b1, keep_of(ptr_q), word_q};
                        err_inc = 1'b1;
                    end else begin
                        ovf_inc = 1'b1;
                    end
                end
            end else if (state_q == StPack) begin
                accept = 1'b1;
            end else if (eof_q) begin
                state_d = StIdle;
            end
        end

        if (accept) begin
            state_d = StPack;
            if (cur_len == 16'(MAX_FRAME)) begin
                // This byte would exceed the limit: drop it and close what is held
                state_d = StDrop;
                ptr_d   = '0;
                len_d   = '0;
                if (cur_pushed || room_last) begin
                    push_d  = 1'b1;
                    pw_d    = {1'b1, 1'b1, keep_of(cur_ptr), word_q};
                    err_inc = 1'b1;
                end else begin
                    ovf_inc = 1'b1;
                end
            end else begin
                word_n = (cur_ptr == '0) ? '0 : word_q;
                for (int i = 0; i < BYTES; i++) begin
                    if (cur_ptr == PW'(i)) word_n[8*i +: 8] = data_q;
                end
                ptr_n    = cur_ptr + PW'(1);
                len_n    = (cur_len == 16'hffff) ? cur_len : cur_len + 16'd1;
                err_n    = cur_err | err_q;
                word_d   = word_n;
                ptr_d    = ptr_n;
                len_d    = len_n;
                ferr_d   = err_n;
                pushed_d = cur_pushed;
                if (eof_q) begin
                    state_d   = StIdle;
                    ptr_d     = '0;
                    len_d     = '0;
                    frame_bad = err_n | (len_n < 16'(MIN_FRAME));
                    if (closing) begin
                        // Only one push per cycle: the closing word wins over this runt
                        ovf_inc = 1'b1;
                    end else if (cur_pushed || room_last) begin
                        push_d    = 1'b1;
                        pw_d      = {frame_bad, 1'b1, keep_of(ptr_n), word_n};
                        err_inc   = frame_bad;
                        frame_inc = ~frame_bad;
                    end else begin
                        ovf_inc = 1'b1;
                    end
                end else if (ptr_n == PW'(BYTES)) begin
                    ptr_d = '0;
                    if (room_mid) begin
                        push_d   = 1'b1;
                        pw_d     = {1'b0, 1'b0, {BYTES{1'b1}}, word_n};
                        pushed_d = 1'b1;
                    end else begin
                        state_d = StDrop;
                        len_d   = '0;
                        ovf_inc = 1'b1;
                        if (cur_pushed) begin
                            push_d  = 1'b1;
                            pw_d    = {1'b1, 1'b1, {BYTES{1'b1}}, word_n};
                            err_inc = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q + 16'(frame_inc);
        err_cnt_d   = err_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        if (err_inc && err_cnt_q != 16'hffff) err_cnt_d = err_cnt_q + 16'd1;
        if (ovf_inc && ovf_cnt_q != 16'hffff) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    always_comb begin
        rd_word  = mem_q[rd_ptr_q];
        pop      = (cnt_q != '0) && m_axis.m_tready;
        wr_ptr_d = wr_ptr_q + AW'(push_q);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + CW'(push_q) - CW'(pop);
    end

    always_comb begin
        m_axis.m_tdata  = rd_word[DW-1:0];
        m_axis.m_tkeep  = rd_word[DW +: BYTES];
        m_axis.m_tlast  = rd_word[DW + BYTES];
        m_axis.m_tuser  = rd_word[DW + BYTES + 1];
        m_axis.m_tvalid = (cnt_q != '0);
        frame_cnt       = frame_cnt_q;
        err_cnt         = err_cnt_q;
        ovf_cnt         = ovf_cnt_q;
    end

    always_ff @(posedge clk125) begin
        if (push_q) mem_q[wr_ptr_q] <= pw_q;
    end

    always_ff @(posedge clk125) begin
        if (rst) begin
            data_q      <= '0;
            val_q       <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= StIdle;
            ptr_q       <= '0;
            len_q       <= '0;
            ferr_q      <= 1'b0;
            pushed_q    <= 1'b0;
            word_q      <= '0;
            push_q      <= 1'b0;
            pw_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            data_q      <= data_d;
            val_q       <= val_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            err_q       <= err_d;
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            len_q       <= len_d;
            ferr_q      <= ferr_d;
            pushed_q    <= pushed_d;
            word_q      <= word_d;
            push_q      <= push_d;
            pw_q        <= pw_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end
endmodule

// File: tb/tb_rgmii_rx_word_packer.sv
// Bench for rgmii_rx_word_packer: frame table, hand-written corner sequences and random
// frames, all checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_rgmii_rx_word_packer;
    localparam int unsigned B     = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MINF  = 64;
    localparam int unsigned MAXF  = 1522;

    typedef struct {
        logic [8*B-1:0] data;
        logic [B-1:0]   keep;
        logic           last;
        logic           user;
    } word_t;

    typedef struct {
        int           len;
        int           err_at;
        int           exp_words;
        logic [B-1:0] exp_keep;
        logic         exp_user;
    } vec_t;

    logic        clk125 = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_val = 1'b0, in_sof = 1'b0, in_eof = 1'b0, in_err = 1'b0;
    logic [15:0] frame_cnt, err_cnt, ovf_cnt;

    rgmii_rx_word_packer_if #(.BYTES(B)) axis ();

    rgmii_rx_word_packer #(
        .BYTES(B), .FIFO_DEPTH(DEPTH), .MIN_FRAME(MINF), .MAX_FRAME(MAXF)
    ) dut (
        .clk125   (clk125),
        .rst      (rst),
        .in_data  (in_data),
        .in_val   (in_val),
        .in_sof   (in_sof),
        .in_eof   (in_eof),
        .in_err   (in_err),
        .m_axis   (axis),
        .frame_cnt(frame_cnt),
        .err_cnt  (err_cnt),
        .ovf_cnt  (ovf_cnt)
    );

    always #4 clk125 = ~clk125;

    int    n_cmp = 0, n_bad = 0;
    int    exp_frame = 0, exp_err = 0, exp_ovf = 0;
    word_t got_q[$], exp_q[$];
    bit    ready_rand = 1'b0;
    logic  ready_val = 1'b1;

    initial begin
        axis.m_tready = 1'b1;
        forever begin
            @(posedge clk125);
            #1;
            axis.m_tready = ready_rand ? ($urandom_range(3) != 0) : ready_val;
        end
    end

    initial begin : collect
        word_t w;
        forever begin
            @(negedge clk125);
            if (!rst && axis.m_tvalid && axis.m_tready) begin
                w.data = axis.m_tdata;
                w.keep = axis.m_tkeep;
                w.last = axis.m_tlast;
                w.user = axis.m_tuser;
                got_q.push_back(w);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic s, input logic e, input logic er);
        @(posedge clk125);
        #1;
        in_val = 1'b1; in_data = d; in_sof = s; in_eof = e; in_err = er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk125);
            #1;
            in_val = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_err = 1'b0;
        end
    endtask

    task automatic drive_frame(input int len, input int err_at, input int seed, input int gap);
        for (int i = 0; i < len; i++) begin
            drive_byte(8'(seed + i), i == 0, i == len - 1, i == err_at);
            if (gap > 0 && i != len - 1 && $urandom_range(7) == 0) idle($urandom_range(1, gap));
        end
    endtask

    // Expected words for one complete frame, from the length/error rules alone
    function automatic void model_frame(input int len, input int err_at, input int seed);
        int    nb, nw;
        bit    trunc, bad;
        word_t w;
        trunc = len > MAXF;
        nb    = trunc ? MAXF : len;
        bad   = trunc || nb < MINF || (err_at >= 0 && err_at < nb);
        nw    = (nb + B - 1) / B;
        if (trunc && nb % B == 0) nw++;
        for (int k = 0; k < nw; k++) begin
            w.data = '0;
            w.keep = '0;
            for (int j = 0; j < B; j++) begin
                if (k * B + j < nb) begin
                    w.data[8*j +: 8] = 8'(seed + k * B + j);
                    w.keep[j] = 1'b1;
                end
            end
            w.last = (k == nw - 1);
            w.user = w.last && bad;
            exp_q.push_back(w);
        end
        if (bad) exp_err++;
        else exp_frame++;
    endfunction

    function automatic void exp_word(input int k, input int seed, input logic [B-1:0] keep,
                                     input logic last, input logic user);
        word_t w;
        for (int j = 0; j < B; j++) w.data[8*j +: 8] = 8'(seed + k * B + j);
        w.keep = keep;
        w.last = last;
        w.user = user;
        exp_q.push_back(w);
    endfunction

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (got_q.size() < exp_q.size() && budget < 4000) begin
            @(posedge clk125);
            budget++;
        end
        repeat (24) @(posedge clk125);
    endtask

    task automatic compare_stream(input string name);
        word_t          g, e;
        logic [8*B-1:0] m;
        bit             ok;
        wait_drain();
        check({name, " word count"}, got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            g = got_q[k];
            e = exp_q[k];
            for (int j = 0; j < B; j++) m[8*j +: 8] = {8{e.keep[j]}};
            ok = (g.keep === e.keep) && (g.last === e.last) && ((g.data & m) === (e.data & m))
                 && (!e.last || g.user === e.user);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL %s word %0d: got data=%h keep=%h last=%b user=%b, expected data=%h keep=%h last=%b user=%b",
                         name, k, g.data, g.keep, g.last, g.user, e.data & m, e.keep, e.last,
                         e.user);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_counters(input string name);
        check({name, " frame_cnt"}, frame_cnt, 16'(exp_frame));
        check({name, " err_cnt"}, err_cnt, 16'(exp_err));
        check({name, " ovf_cnt"}, ovf_cnt, 16'(exp_ovf));
    endtask

    initial begin
        vec_t tbl[8];
        int   len, err_at;

        tbl[0] = '{64,   -1, 16,  4'hF, 1'b0};
        tbl[1] = '{65,   -1, 17,  4'h1, 1'b0};
        tbl[2] = '{63,   -1, 16,  4'h7, 1'b1};
        tbl[3] = '{100,  10, 25,  4'hF, 1'b1};
        tbl[4] = '{1,    -1, 1,   4'h1, 1'b1};
        tbl[5] = '{1600, -1, 381, 4'h3, 1'b1};
        tbl[6] = '{1522, -1, 381, 4'h3, 1'b0};
        tbl[7] = '{1523, -1, 381, 4'h3, 1'b1};

        repeat (3) @(posedge clk125);
        #1 rst = 1'b0;
        check("reset tvalid", axis.m_tvalid, 1'b0);
        check_counters("reset");

        // Latency: 1-byte runt held with tready low
        ready_val = 1'b0;
        repeat (2) @(posedge clk125);
        drive_byte(8'hA5, 1'b1, 1'b1, 1'b0);
        idle(1);
        @(posedge clk125);
        #1 check("latency edge+1 tvalid", axis.m_tvalid, 1'b0);
        @(posedge clk125);
        #1 check("latency edge+2 tvalid", axis.m_tvalid, 1'b1);
        check("runt tkeep", axis.m_tkeep, 4'h1);
        check("runt tlast/tuser", {axis.m_tlast, axis.m_tuser}, 2'b11);
        check("runt tdata", axis.m_tdata[7:0], 8'hA5);
        model_frame(1, -1, 'hA5);
        ready_val = 1'b1;
        compare_stream("latency");
        check_counters("latency");

        for (int r = 0; r < 8; r++) begin
            drive_frame(tbl[r].len, tbl[r].err_at, r * 17, 0);
            idle(4);
            model_frame(tbl[r].len, tbl[r].err_at, r * 17);
            wait_drain();
            check($sformatf("table %0d words", r), got_q.size(), tbl[r].exp_words);
            if (got_q.size() > 0) begin
                check($sformatf("table %0d last keep", r), got_q[$].keep, tbl[r].exp_keep);
                check($sformatf("table %0d last tlast/tuser", r),
                      {got_q[$].last, got_q[$].user}, {1'b1, tbl[r].exp_user});
                if (r == 0) check("table 0 first tdata", got_q[0].data, 32'h03020100);
            end
            compare_stream($sformatf("table %0d", r));
            check_counters($sformatf("table %0d", r));
        end

        // Overflow: 128-byte frame into a FIFO nobody reads
        ready_val = 1'b0;
        repeat (2) @(posedge clk125);
        drive_frame(128, -1, 0, 0);
        idle(8);
        check("overflow tvalid", axis.m_tvalid, 1'b1);
        for (int k = 0; k < 15; k++) exp_word(k, 0, 4'hF, k == 14, k == 14);
        exp_err++;
        exp_ovf++;
        check_counters("overflow");
        ready_val = 1'b1;
        compare_stream("overflow");

        // sof inside an open frame at byte 8
        for (int i = 0; i < 8; i++) drive_byte(8'(8'h80 + i), i == 0, 1'b0, 1'b0);
        drive_frame(64, -1, 'h90, 0);
        idle(4);
        exp_word(0, 'h80, 4'hF, 1'b0, 1'b0);
        exp_word(1, 'h80, 4'hF, 1'b0, 1'b0);
        exp_word(2, 'h80, 4'h0, 1'b1, 1'b1);
        exp_err++;
        model_frame(64, -1, 'h90);
        compare_stream("sof in frame");
        check_counters("sof in frame");

        // Reset mid-frame: partial words held, then everything cleared
        ready_val = 1'b0;
        repeat (2) @(posedge clk125);
        for (int i = 0; i < 10; i++) drive_byte(8'(i), i == 0, 1'b0, 1'b0);
        @(posedge clk125);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk125);
        #1 rst = 1'b0;
        exp_frame = 0;
        exp_err = 0;
        exp_ovf = 0;
        ready_val = 1'b1;
        for (int i = 0; i < 10; i++) drive_byte(8'(8'h40 + i), 1'b0, i == 9, 1'b0);
        idle(30);
        check("reset mid-frame words", got_q.size(), 0);
        check("reset mid-frame tvalid", axis.m_tvalid, 1'b0);
        check_counters("reset mid-frame");
        drive_frame(64, -1, 'h33, 0);
        idle(4);
        model_frame(64, -1, 'h33);
        compare_stream("after reset");
        check_counters("after reset");

        // Random frames, gaps and downstream stalls
        ready_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len    = $urandom_range(1, 300);
            err_at = ($urandom_range(9) == 0) ? $urandom_range(len - 1) : -1;
            drive_frame(len, err_at, f * 29 + 7, 3);
            model_frame(len, err_at, f * 29 + 7);
            idle($urandom_range(0, 4));
        end
        idle(4);
        compare_stream("random");
        check_counters("random");
        ready_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
